// File: rtl/gpio_pkg.sv
// Shared constants for the Wishbone GPIO block: register byte offsets, reset values
// and the byte-lane write-mask helper.
package gpio_pkg;

    localparam logic [7:0] OFF_OUT      = 8'h00;
    localparam logic [7:0] OFF_OEB      = 8'h04;
    localparam logic [7:0] OFF_IN       = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h10;
    localparam logic [7:0] OFF_ID       = 8'h14;
    localparam logic [7:0] OFF_EDGE     = 8'h18;

    localparam logic [31:0] RST_OUT      = 32'h0000_0000;
    localparam logic [31:0] RST_OEB      = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_IRQ_EN   = 32'h0000_0000;
    localparam logic [31:0] RST_IRQ_STAT = 32'h0000_0000;
    localparam logic [31:0] RST_EDGE     = 32'h0000_0000;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                m[8*b +: 8] = 8'hFF;
            end else begin
                m[8*b +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic slave bus bundle between the wrapper (master) and wb_gpio_irq (slave).
interface wb_gpio_irq_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/gpio_sync.sv
// Pad input path: 2-flop synchronizer, previous-value flop and per-bit edge detect
// (rising, or falling where edge_sel is set); edges are suppressed for 3 cycles after reset.
module gpio_sync #(
    parameter int unsigned NIO = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NIO-1:0] io_in,
    input  logic [NIO-1:0] edge_sel,
    output logic [NIO-1:0] in_sync,
    output logic [NIO-1:0] edge_det
);

    logic [NIO-1:0] sync1_r;
    logic [NIO-1:0] sync2_r;
    logic [NIO-1:0] prev_r;
    logic [1:0]     mask_cnt_r;
    logic [NIO-1:0] rise_s;
    logic [NIO-1:0] fall_s;

    // Synchronizer chain and previous-value flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= io_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Saturating counter that arms edge detection once the chain holds real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_cnt_r <= 2'd0;
        end else if (mask_cnt_r != 2'd3) begin
            mask_cnt_r <= mask_cnt_r + 2'd1;
        end
    end

    // Edge select and post-reset masking
    always_comb begin
        rise_s = sync2_r & ~prev_r;
        fall_s = ~sync2_r & prev_r;
        if (mask_cnt_r == 2'd3) begin
            edge_det = (rise_s & ~edge_sel) | (fall_s & edge_sel);
        end else begin
            edge_det = '0;
        end
    end

    assign in_sync = sync2_r;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave with sticky input-edge status and a level interrupt.
// Optional per-bit falling-edge select register when GPIO_EDGE_SEL_EN is defined.
module wb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int unsigned NIO       = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h6770_0001
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    wb_gpio_irq_if.slave   wb,
    input  logic [NIO-1:0] io_in,
    output logic [NIO-1:0] io_out,
    output logic [NIO-1:0] io_oeb,
    output logic           irq_o
);

    logic           hit_s;
    logic           req_s;
    logic           wr_s;
    logic [7:0]     off_s;
    logic [31:0]    lane_s;
    logic [NIO-1:0] wm_s;
    logic [NIO-1:0] wd_s;
    logic [31:0]    rd_data_s;
    logic [NIO-1:0] clr_s;
    logic [NIO-1:0] stat_nxt_s;
    logic [NIO-1:0] in_s;
    logic [NIO-1:0] edge_s;
    logic [NIO-1:0] edge_sel_s;
    logic           unused_s;

    logic           ack_r;
    logic [31:0]    dat_r;
    logic [NIO-1:0] out_r;
    logic [NIO-1:0] oeb_r;
    logic [NIO-1:0] en_r;
    logic [NIO-1:0] stat_r;
    logic           irq_r;

    // A request is never taken while ack is high, so held strobes ack every other cycle
    assign hit_s    = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req_s    = wb.wbs_stb_i & wb.wbs_cyc_i & hit_s & ~ack_r;
    assign wr_s     = req_s & wb.wbs_we_i;
    assign off_s    = {wb.wbs_adr_i[7:2], 2'b00};
    assign lane_s   = lane_mask(wb.wbs_sel_i);
    assign wm_s     = lane_s[NIO-1:0];
    assign wd_s     = wb.wbs_dat_i[NIO-1:0];
    assign unused_s = ^wb.wbs_adr_i[1:0];

    gpio_sync #(.NIO(NIO)) u_sync (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .io_in    (io_in),
        .edge_sel (edge_sel_s),
        .in_sync  (in_s),
        .edge_det (edge_s)
    );

`ifdef GPIO_EDGE_SEL_EN
    logic [NIO-1:0] edge_r;

    // Edge polarity register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            edge_r <= RST_EDGE[NIO-1:0];
        end else if (wr_s && (off_s == OFF_EDGE)) begin
            edge_r <= (edge_r & ~wm_s) | (wd_s & wm_s);
        end
    end

    assign edge_sel_s = edge_r;
`else
    assign edge_sel_s = '0;
`endif

    // Read mux; unimplemented bits and offsets read as zero
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (off_s)
            OFF_OUT:      rd_data_s[NIO-1:0] = out_r;
            OFF_OEB:      rd_data_s[NIO-1:0] = oeb_r;
            OFF_IN:       rd_data_s[NIO-1:0] = in_s;
            OFF_IRQ_EN:   rd_data_s[NIO-1:0] = en_r;
            OFF_IRQ_STAT: rd_data_s[NIO-1:0] = stat_r;
            OFF_ID:       rd_data_s          = ID_VALUE;
`ifdef GPIO_EDGE_SEL_EN
            OFF_EDGE:     rd_data_s[NIO-1:0] = edge_r;
`endif
            default:      rd_data_s          = 32'h0000_0000;
        endcase
    end

    // Status update: W1C clear first, then OR in new edges so a same-cycle set wins
    always_comb begin
        if (wr_s && (off_s == OFF_IRQ_STAT)) begin
            clr_s = wd_s & wm_s;
        end else begin
            clr_s = '0;
        end
        stat_nxt_s = (stat_r & ~clr_s) | edge_s;
    end

    // Bus handshake and registered read data
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= req_s;
            if (req_s && !wb.wbs_we_i) begin
                dat_r <= rd_data_s;
            end
        end
    end

    // Control/status registers and interrupt output
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_r  <= RST_OUT[NIO-1:0];
            oeb_r  <= RST_OEB[NIO-1:0];
            en_r   <= RST_IRQ_EN[NIO-1:0];
            stat_r <= RST_IRQ_STAT[NIO-1:0];
            irq_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                case (off_s)
                    OFF_OUT:    out_r <= (out_r & ~wm_s) | (wd_s & wm_s);
                    OFF_OEB:    oeb_r <= (oeb_r & ~wm_s) | (wd_s & wm_s);
                    OFF_IRQ_EN: en_r  <= (en_r  & ~wm_s) | (wd_s & wm_s);
                    default:    ;
                endcase
            end
            stat_r <= stat_nxt_s;
            irq_r  <= |(stat_r & en_r);
        end
    end

    assign wb.wbs_ack_o = ack_r;
    assign wb.wbs_dat_o = dat_r;
    assign io_out       = out_r;
    assign io_oeb       = oeb_r;
    assign irq_o        = irq_r;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: directed vector table, hand-timed corner cases,
// and randomized bus/pad traffic checked against a register-level reference model.
module tb_wb_gpio_irq;

    localparam int          NIO  = 32;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ID   = 32'h6770_0001;
`ifdef GPIO_EDGE_SEL_EN
    localparam bit EDGE_IMPL = 1'b1;
`else
    localparam bit EDGE_IMPL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NIO-1:0] io_in = '0;
    logic [NIO-1:0] io_out;
    logic [NIO-1:0] io_oeb;
    logic           irq;
    int             total = 0;
    int             bad = 0;

    logic [31:0] m_out, m_oeb, m_en, m_stat, m_edge, m_io;

    typedef struct {
        logic [7:0]  off;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[17];

    wb_gpio_irq_if bus();

    wb_gpio_irq #(.NIO(NIO), .BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb        (bus),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        chk("rst_dat", bus.wbs_dat_o, 32'h0);
        chk("rst_out", io_out, 32'h0);
        chk("rst_oeb", io_oeb, 32'hFFFF_FFFF);
        chk("rst_irq", {31'h0, irq}, 32'h0);
    endtask

    // One bounded bus transaction; also checks 1-cycle ack latency and width
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, output logic [31:0] rdat, output logic acked);
        int n;
        acked = 1'b0;
        rdat  = 32'h0;
        n     = 0;
        @(posedge clk); #1;
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = wdat;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        while (!acked && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (bus.wbs_ack_o) begin
                acked = 1'b1;
                rdat  = bus.wbs_dat_o;
            end
        end
        bus_idle();
        if (acked) begin
            chk("ack_lat", n, 1);
            @(posedge clk); #1;
            chk("ack_width", {31'h0, bus.wbs_ack_o}, 32'h0);
        end
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        logic        a;
        wb_xfer(BASE + {24'h0, off}, 1'b0, 4'hF, 32'h0, d, a);
        chk({nm, "_ack"}, {31'h0, a}, 32'h1);
        chk(nm, d, exp);
    endtask

    task automatic wr(input logic [7:0] off, input logic [3:0] sel, input logic [31:0] dat,
                      input string nm);
        logic [31:0] d;
        logic        a;
        wb_xfer(BASE + {24'h0, off}, 1'b1, sel, dat, d, a);
        chk({nm, "_ack"}, {31'h0, a}, 32'h1);
    endtask

    function automatic logic [31:0] bytes_of(input logic [3:0] sel);
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return m;
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] m;
        m = bytes_of(sel);
        case (off)
            8'h00: m_out = (m_out & ~m) | (d & m);
            8'h04: m_oeb = (m_oeb & ~m) | (d & m);
            8'h0C: m_en  = (m_en & ~m) | (d & m);
            8'h10: m_stat = m_stat & ~(d & m);
            8'h18: if (EDGE_IMPL) m_edge = (m_edge & ~m) | (d & m);
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00: return m_out;
            8'h04: return m_oeb;
            8'h08: return m_io;
            8'h0C: return m_en;
            8'h10: return m_stat;
            8'h14: return ID;
            8'h18: return EDGE_IMPL ? m_edge : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_io(input logic [31:0] nv);
        logic [31:0] rise, fall;
        rise = nv & ~m_io;
        fall = ~nv & m_io;
        m_stat = m_stat | (EDGE_IMPL ? ((rise & ~m_edge) | (fall & m_edge)) : rise);
        m_io = nv;
    endtask

    initial begin
        logic        seen;
        logic [7:0]  off;
        logic [3:0]  sel;
        logic [31:0] d, nv;
        int          op;

        bus_idle();
        tbl[0]  = '{8'h04, 1'b0, 4'hF, 32'h0,         32'hFFFF_FFFF};
        tbl[1]  = '{8'h00, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[2]  = '{8'h14, 1'b0, 4'hF, 32'h0,         ID};
        tbl[3]  = '{8'h00, 1'b1, 4'h2, 32'hA5A5_A5A5, 32'h0};
        tbl[4]  = '{8'h00, 1'b0, 4'hF, 32'h0,         32'h0000_A500};
        tbl[5]  = '{8'h04, 1'b1, 4'hF, 32'h1234_5678, 32'h0};
        tbl[6]  = '{8'h04, 1'b0, 4'hF, 32'h0,         32'h1234_5678};
        tbl[7]  = '{8'h04, 1'b1, 4'h9, 32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{8'h04, 1'b0, 4'hF, 32'h0,         32'hFF34_56FF};
        tbl[9]  = '{8'h08, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0};
        tbl[10] = '{8'h08, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[11] = '{8'h14, 1'b1, 4'hF, 32'h0,         32'h0};
        tbl[12] = '{8'h14, 1'b0, 4'hF, 32'h0,         ID};
        tbl[13] = '{8'h40, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[14] = '{8'h18, 1'b1, 4'hF, 32'h1,         32'h0};
        tbl[15] = '{8'h18, 1'b0, 4'hF, 32'h0,         EDGE_IMPL ? 32'h1 : 32'h0};
        tbl[16] = '{8'h18, 1'b1, 4'hF, 32'h0,         32'h0};

        do_reset();
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].we) begin
                wr(tbl[i].off, tbl[i].sel, tbl[i].wdat, $sformatf("vec%0d_wr", i));
            end else begin
                rd(tbl[i].off, tbl[i].exp, $sformatf("vec%0d_rd", i));
            end
        end
        chk("tbl_io_out", io_out, 32'h0000_A500);
        chk("tbl_io_oeb", io_oeb, 32'hFF34_56FF);

        // Rising edge on bit 3: IN after 2 edges, STAT after 3, irq after 4
        wr(8'h0C, 4'hF, 32'h8, "en_wr");
        @(posedge clk); #1;
        io_in[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("irq_early", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("irq_rise", {31'h0, irq}, 32'h1);
        rd(8'h08, 32'h8, "in_bit3");
        rd(8'h10, 32'h8, "stat_bit3");
        wr(8'h10, 4'hF, 32'h8, "w1c_wr");
        @(posedge clk); #1;
        chk("irq_clear", {31'h0, irq}, 32'h0);
        rd(8'h10, 32'h0, "stat_clear");

        // Edge on bit 5 reaches STAT on the same edge that the W1C is taken
        @(posedge clk); #1;
        io_in[5] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus.wbs_adr_i = BASE + 32'h10;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = 32'h20;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        chk("coll_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
        bus_idle();
        rd(8'h10, 32'h20, "coll_stat");

        // Reset hits an in-flight request with all pads high
        @(posedge clk); #1;
        io_in = '1;
        bus.wbs_adr_i = BASE;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_noack", {31'h0, bus.wbs_ack_o}, 32'h0);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        rd(8'h10, 32'h0, "mask_stat");
        rd(8'h08, 32'hFFFF_FFFF, "mask_in");
        rd(8'h00, 32'h0, "post_rst_out");
        rd(8'h40, 32'h0, "unmapped_rd");
        @(posedge clk); #1;
        bus.wbs_adr_i = BASE + 32'h100;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) seen = 1'b1;
        end
        bus_idle();
        chk("unsel_noack", {31'h0, seen}, 32'h0);

`ifdef GPIO_EDGE_SEL_EN
        wr(8'h18, 4'hF, 32'h1, "edge_wr");
        @(posedge clk); #1;
        io_in[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rd(8'h10, 32'h1, "fall_stat");
`else
        rd(8'h18, 32'h0, "edge_unmapped");
`endif

        // Randomized traffic against the reference model
        io_in = '0;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        m_out = 32'h0; m_oeb = 32'hFFFF_FFFF; m_en = 32'h0;
        m_stat = 32'h0; m_edge = 32'h0; m_io = 32'h0;
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    off = 8'($urandom_range(0, 7) * 4);
                    sel = 4'($urandom);
                    d   = $urandom;
                    wr(off, sel, d, "rnd_wr");
                    model_write(off, sel, d);
                    @(posedge clk); #1;
                end
                1: begin
                    off = 8'($urandom_range(0, 7) * 4);
                    rd(off, model_read(off), "rnd_rd");
                end
                2: begin
                    nv = $urandom;
                    if ($urandom_range(0, 1) == 1) nv = m_io ^ (32'h1 << $urandom_range(0, 31));
                    io_in = nv;
                    model_io(nv);
                    repeat (5) @(posedge clk);
                    #1;
                end
                default: begin
                    repeat (2) @(posedge clk);
                    #1;
                end
            endcase
            chk("rnd_irq", {31'h0, irq}, {31'h0, |(m_stat & m_en)});
            chk("rnd_out", io_out, m_out);
            chk("rnd_oeb", io_oeb, m_oeb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
